// File: rtl/wbdbgbus_host.sv
// Host side of the UART Wishbone debug bus: frames 36-bit commands
// into 5 UART bytes and decodes 5-byte responses and interrupt frames.

module uart_tx #(
  parameter int CLK_FREQ  = 25000000,
  parameter int UART_BAUD = 9600
) (
  input  logic       i_clk,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx
);
  localparam int CPB = CLK_FREQ / UART_BAUD;
  localparam int CW  = $clog2(CPB) + 1;
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);

  logic          busy;
  logic          line_n;
  logic [CW-1:0] cnt;
  logic [3:0]    bitn;
  logic [8:0]    shr;

  // Line is stored inverted so an all-zero power-up state idles high.
  assign o_tx    = ~line_n;
  assign o_ready = ~busy;

  always_ff @(posedge i_clk) begin
    if (!busy) begin
      if (i_valid) begin
        busy   <= 1'b1;
        shr    <= {1'b1, i_data};
        line_n <= 1'b1;
        cnt    <= '0;
        bitn   <= '0;
      end
    end else if (cnt == FULL) begin
      cnt <= '0;
      if (bitn == 4'd9) begin
        busy <= 1'b0;
      end else begin
        line_n <= ~shr[0];
        shr    <= {1'b1, shr[8:1]};
        bitn   <= bitn + 4'd1;
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module uart_rx #(
  parameter int CLK_FREQ  = 25000000,
  parameter int UART_BAUD = 9600
) (
  input  logic       i_clk,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid
);
  localparam int CPB = CLK_FREQ / UART_BAUD;
  localparam int CW  = $clog2(CPB) + 1;
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);

  logic [1:0]    sync_n;
  logic          line_lo;
  logic          busy;
  logic [CW-1:0] cnt;
  logic [3:0]    bitn;
  logic [7:0]    shr;

  assign line_lo = sync_n[1];

  always_ff @(posedge i_clk) begin
    sync_n  <= {sync_n[0], ~i_rx};
    o_valid <= 1'b0;
    if (!busy) begin
      if (line_lo) begin
        busy <= 1'b1;
        cnt  <= '0;
        bitn <= '0;
      end
    end else if (bitn == 4'd0) begin
      if (cnt == HALF) begin
        cnt <= '0;
        if (line_lo) bitn <= 4'd1;
        else         busy <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (cnt == FULL) begin
      cnt <= '0;
      if (bitn == 4'd9) begin
        busy    <= 1'b0;
        o_valid <= ~line_lo;
        o_data  <= shr;
      end else begin
        shr  <= {~line_lo, shr[7:1]};
        bitn <= bitn + 4'd1;
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module wbdbgbus_host #(
  parameter int CLK_FREQ  = 25000000,
  parameter int UART_BAUD = 9600,
  parameter int DROP_CLKS = 2500000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_tx,
  input  logic        i_rx,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [35:0] i_cmd_data,
  input  logic        i_cmd_reset,
  output logic        o_resp_valid,
  output logic [35:0] o_resp_data,
  output logic [3:0]  o_interrupt,
  output logic        o_frame_dropped
);
  localparam int TW = $clog2(DROP_CLKS) + 1;
  localparam logic [TW-1:0] DROP = TW'(DROP_CLKS);

  typedef enum logic {IDLE, SEND} tx_state_t;

  tx_state_t   state;
  logic [2:0]  idx;
  logic [35:0] cmd;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  cur_byte;

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [2:0]  rcnt;
  logic [27:0] rbuf;
  logic [35:0] frame;
  logic [TW-1:0] tmr;

  uart_tx #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BAUD(UART_BAUD)
  ) u_tx (
    .i_clk  (i_clk),
    .i_data (tx_byte),
    .i_valid(tx_valid),
    .o_ready(tx_ready),
    .o_tx   (o_tx)
  );

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BAUD(UART_BAUD)
  ) u_rx (
    .i_clk  (i_clk),
    .i_rx   (i_rx),
    .o_data (rx_byte),
    .o_valid(rx_valid)
  );

  always_comb begin
    cur_byte = cmd[7:0];
    case (idx)
      3'd0:    cur_byte = {4'b0000, cmd[35:32]};
      3'd1:    cur_byte = cmd[31:24];
      3'd2:    cur_byte = cmd[23:16];
      3'd3:    cur_byte = cmd[15:8];
      default: cur_byte = cmd[7:0];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      idx         <= '0;
      cmd         <= '0;
      tx_byte     <= '0;
      tx_valid    <= 1'b0;
      o_cmd_ready <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          o_cmd_ready <= 1'b1;
          if (o_cmd_ready && (i_cmd_reset || i_cmd_valid)) begin
            cmd         <= i_cmd_reset ? 36'hF_0000_0000 : i_cmd_data;
            idx         <= '0;
            state       <= SEND;
            o_cmd_ready <= 1'b0;
          end
        end
        SEND: begin
          // idx==5 is the cycle byte 4 sits on uart_tx's input
          if (idx == 3'd5) begin
            state       <= IDLE;
            o_cmd_ready <= 1'b1;
          end else if (tx_ready && !tx_valid) begin
            tx_valid <= 1'b1;
            tx_byte  <= cur_byte;
            idx      <= idx + 3'd1;
          end
        end
      endcase
    end
  end

  // Byte0's upper nibble falls off the top of the 36-bit frame.
  assign frame = {rbuf, rx_byte};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rcnt            <= '0;
      rbuf            <= '0;
      tmr             <= DROP;
      o_resp_valid    <= 1'b0;
      o_resp_data     <= '0;
      o_interrupt     <= '0;
      o_frame_dropped <= 1'b0;
    end else begin
      o_resp_valid    <= 1'b0;
      o_interrupt     <= '0;
      o_frame_dropped <= 1'b0;
      if (rx_valid) begin
        tmr <= DROP;
        if (rcnt == 3'd4) begin
          rcnt <= '0;
          if (frame[35:34] == 2'b10) begin
            o_interrupt <= 4'b0001 << frame[33:32];
          end else begin
            o_resp_data  <= frame;
            o_resp_valid <= 1'b1;
          end
        end else begin
          rcnt <= rcnt + 3'd1;
          rbuf <= {rbuf[19:0], rx_byte};
        end
      end else if (rcnt != 3'd0) begin
        if (tmr == TW'(1)) begin
          rcnt            <= '0;
          tmr             <= DROP;
          o_frame_dropped <= 1'b1;
        end else begin
          tmr <= tmr - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_wbdbgbus_host.sv
// Bench for wbdbgbus_host: bit-level line model on both UART wires,
// queue scoreboards for TX bytes, responses and interrupts.

module tb_wbdbgbus_host;
  localparam int CPB  = 8;
  localparam int DROP = 100;

  logic        clk;
  logic        rst;
  logic        o_tx;
  logic        i_rx;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [35:0] cmd_data;
  logic        cmd_reset;
  logic        resp_valid;
  logic [35:0] resp_data;
  logic [3:0]  intr;
  logic        dropped;

  wbdbgbus_host #(
    .CLK_FREQ (800000),
    .UART_BAUD(100000),
    .DROP_CLKS(DROP)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .o_tx           (o_tx),
    .i_rx           (i_rx),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (cmd_ready),
    .i_cmd_data     (cmd_data),
    .i_cmd_reset    (cmd_reset),
    .o_resp_valid   (resp_valid),
    .o_resp_data    (resp_data),
    .o_interrupt    (intr),
    .o_frame_dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_stop = 0;
  int drop_cnt = 0;
  bit tx_chk = 0;
  logic [35:0] model_resp = '0;

  logic [7:0]  txq[$];
  logic [35:0] respq[$];
  logic [3:0]  intq[$];

  typedef struct {
    bit          rx;
    logic [35:0] cmd;
    logic [39:0] bytes;
    bit          ev;
    logic [35:0] edata;
    logic [3:0]  eint;
  } vec_t;

  vec_t tbl[10];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event want none", nm);
  endtask

  // TX line decoder
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (o_tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = o_tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx_chk) begin
          if (txq.size() == 0) fail("tx_unexpected");
          else chk("tx_byte", b, txq.pop_front());
        end
      end
    end
  end

  // Response / interrupt / drop monitor
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (respq.size() == 0) fail("resp_unexpected");
      else begin
        chk("resp_data", resp_data, respq.pop_front());
        chk("resp_lat",
            (cyc - last_stop >= 2) && (cyc - last_stop <= 16), 1);
      end
    end
    if (intr !== 4'b0000) begin
      if (intq.size() == 0) fail("int_unexpected");
      else chk("int_line", intr, intq.pop_front());
    end
    if (dropped === 1'b1) drop_cnt++;
  end

  task automatic push_tx(logic [39:0] f);
    for (int k = 0; k < 5; k++) txq.push_back(f[39-8*k -: 8]);
  endtask

  task automatic send_rx(logic [39:0] f, int nb);
    logic [7:0] b;
    for (int k = 0; k < nb; k++) begin
      b = f[39-8*k -: 8];
      i_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        i_rx = b[i];
        repeat (CPB) @(negedge clk);
      end
      i_rx = 1'b1;
      last_stop = cyc;
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic wait_ready();
    for (int t = 0; t < 3000 && !cmd_ready; t++) @(negedge clk);
    chk("ready_wait", cmd_ready, 1);
  endtask

  task automatic send_cmd(logic [35:0] d);
    int n;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ready_low", cmd_ready, 0);
    n = 0;
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_span", (n >= 320) && (n <= 360), 1);
  endtask

  task automatic drain_tx();
    for (int t = 0; t < 3000 && txq.size() != 0; t++) @(negedge clk);
    chk("tx_drain", txq.size(), 0);
  endtask

  initial begin
    tbl[0] = '{0, 36'h2_DEAD_BEEF, 40'h02_DEAD_BEEF, 0, '0, '0};
    tbl[1] = '{0, 36'hF_0123_4567, 40'h0F_0123_4567, 0, '0, '0};
    tbl[2] = '{0, 36'h0_0000_0000, 40'h00_0000_0000, 0, '0, '0};
    tbl[3] = '{0, 36'h7_FFFF_FFFF, 40'h07_FFFF_FFFF, 0, '0, '0};
    tbl[4] = '{1, '0, 40'h04_1234_5678, 1, 36'h4_1234_5678, 4'b0000};
    tbl[5] = '{1, '0, 40'h0A_0000_0000, 0, '0, 4'b0100};
    tbl[6] = '{1, '0, 40'hF5_AABB_CCDD, 1, 36'h5_AABB_CCDD, 4'b0000};
    tbl[7] = '{1, '0, 40'h08_0000_0000, 0, '0, 4'b0001};
    tbl[8] = '{1, '0, 40'h0B_FFFF_FFFF, 0, '0, 4'b1000};
    tbl[9] = '{1, '0, 40'h0C_0000_0001, 1, 36'hC_0000_0001, 4'b0000};

    rst = 1'b1;
    i_rx = 1'b1;
    cmd_valid = 1'b0;
    cmd_reset = 1'b0;
    cmd_data = '0;
    repeat (200) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_rvalid", resp_valid, 0);
    chk("rst_rdata", resp_data, 0);
    chk("rst_int", intr, 0);
    chk("rst_drop", dropped, 0);
    chk("rst_tx", o_tx, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);
    repeat (5) @(negedge clk);
    tx_chk = 1;

    for (int v = 0; v < 10; v++) begin
      if (!tbl[v].rx) begin
        push_tx(tbl[v].bytes);
        send_cmd(tbl[v].cmd);
        drain_tx();
      end else begin
        if (tbl[v].ev) begin
          respq.push_back(tbl[v].edata);
          model_resp = tbl[v].edata;
        end
        if (tbl[v].eint != 4'b0000) intq.push_back(tbl[v].eint);
        send_rx(tbl[v].bytes, 5);
        repeat (20) @(negedge clk);
        chk("rx_done", respq.size() + intq.size(), 0);
        chk("resp_hold", resp_data, model_resp);
      end
    end

    // reset request wins over a simultaneous held command
    push_tx(40'h0F_0000_0000);
    push_tx(40'h01_0000_0010);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_reset = 1'b1;
    cmd_data  = 36'h1_0000_0010;
    @(negedge clk);
    cmd_reset = 1'b0;
    chk("rq_ready_low", cmd_ready, 0);
    wait_ready();
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rq_cmd_taken", cmd_ready, 0);
    drain_tx();

    // partial frame timeout, then a clean frame
    send_rx(40'h01_1122_3344, 3);
    begin
      int t0;
      int d0;
      t0 = cyc;
      d0 = drop_cnt;
      for (int t = 0; t < 400 && drop_cnt == d0; t++) @(negedge clk);
      chk("drop_seen", drop_cnt, d0 + 1);
      chk("drop_time", (cyc - t0 >= 80) && (cyc - t0 <= 115), 1);
    end
    respq.push_back(36'h3_0000_0001);
    model_resp = 36'h3_0000_0001;
    send_rx(40'h03_0000_0001, 5);
    repeat (20) @(negedge clk);
    chk("after_drop", respq.size(), 0);

    // full duplex without reset
    push_tx(40'h0A_5555_AAAA);
    intq.push_back(4'b0010);
    fork
      send_cmd(36'hA_5555_AAAA);
      send_rx(40'h09_0000_0000, 5);
    join
    drain_tx();
    repeat (20) @(negedge clk);
    chk("fd_int", intq.size(), 0);
    chk("fd_hold", resp_data, model_resp);

    // full duplex, reset lands during TX byte 2
    tx_chk = 0;
    fork
      begin
        respq.push_back(36'h6_CAFE_F00D);
        send_rx(40'h06_CAFE_F00D, 5);
      end
      begin
        repeat (230) @(negedge clk);
        chk("fdr_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_data  = 36'h1_2345_6789;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (210) @(negedge clk);
      end
    join
    chk("fdr_resp", respq.size(), 0);
    chk("fdr_busy", cmd_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("fdr_rst_ready", cmd_ready, 0);
    chk("fdr_rst_rdata", resp_data, 0);
    chk("fdr_rst_rvalid", resp_valid, 0);
    chk("fdr_rst_int", intr, 0);
    chk("fdr_rst_drop", dropped, 0);
    @(negedge clk);
    rst = 1'b0;
    model_resp = '0;
    @(negedge clk);
    chk("fdr_ready_after", cmd_ready, 1);
    repeat (200) @(negedge clk);
    txq.delete();
    tx_chk = 1;

    // reset mid RX frame: no drop pulse, next frame clean
    send_rx(40'h07_1111_1111, 2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    respq.push_back(36'h5_0000_002A);
    model_resp = 36'h5_0000_002A;
    send_rx(40'h05_0000_002A, 5);
    repeat (20) @(negedge clk);
    chk("rxrst_resp", respq.size(), 0);
    chk("drop_total", drop_cnt, 1);

    push_tx(40'h0E_0BAD_F00D);
    send_cmd(36'hE_0BAD_F00D);
    drain_tx();
    repeat (20) @(negedge clk);
    chk("end_txq", txq.size(), 0);
    chk("end_intq", intq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
